// File: rtl/response_encoder_if.sv
// Encoder bus: send request and frame data from the control side, plus the
// byte/start/busy path to the UART transmitter and the frame status flags.
interface response_encoder_if #(
  parameter int PAYLOAD_BYTES = 4
);
  // cmd_send is accepted only on a cycle where busy=0 (and not during done);
  // tx_start is a one-cycle strobe qualifying tx_byte, issued only while
  // tx_busy=0. The transmitter raises tx_busy while it shifts that byte out.
  logic                       cmd_send;
  logic [7:0]                 opcode;
  logic [8*PAYLOAD_BYTES-1:0] command;
  logic                       tx_busy;
  logic [7:0]                 tx_byte;
  logic                       tx_start;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output cmd_send, opcode, command, tx_busy,
    input  tx_byte, tx_start, busy, done, err
  );

  modport slave (
    input  cmd_send, opcode, command, tx_busy,
    output tx_byte, tx_start, busy, done, err
  );
endinterface

// File: rtl/response_encoder.sv
// Serialises one response frame (opcode, payload MSB-first, optional XOR
// checksum) into single bytes for the UART transmitter, pacing on tx_busy.
module response_encoder #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int CHECKSUM_EN   = 0,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                clock,
  input  logic                reset,
  response_encoder_if.slave   bus,
  output logic [2:0]          dbg_state_o
);
  localparam int N  = 1 + PAYLOAD_BYTES + CHECKSUM_EN;
  localparam int FW = 8 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_start_q, tx_start_d;
  logic          err_q, err_d;
  logic [FW-1:0] capture;

  // The checksum is folded into the frame at capture, so the shifter sends it
  // like any other byte.
  if (CHECKSUM_EN != 0) begin : g_csum
    logic [7:0] csum;
    always_comb begin
      csum = bus.opcode;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
        csum = csum ^ bus.command[8*i +: 8];
      end
    end
    assign capture = {bus.opcode, bus.command, csum};
  end else begin : g_no_csum
    assign capture = {bus.opcode, bus.command};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_send) begin
          frame_d = capture;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Next byte always sits in the top of the shift register.
        if (!bus.tx_busy) begin
          tx_byte_d  = frame_q[FW-1 -: 8];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            frame_d = frame_q << 8;
            state_d = START;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = (state_q == START) || (state_q == WAIT_HI) || (state_q == WAIT_LO);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_response_encoder.sv
// Bench: two encoders (plain / checksum with short timeout) share one stimulus
// stream; each has its own transmitter model and byte scoreboard.
module tb_response_encoder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_send = 1'b0;
  logic [7:0]  opcode = '0;
  logic [31:0] command = '0;
  logic        force_busy = 1'b0;
  logic        never_ack = 1'b0;
  int          tx_len = 10;
  logic [2:0]  dbg0, dbg1;
  int          tcnt0, tcnt1;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  int          cmp_cnt = 0;
  int          fail_cnt = 0;
  int          exp_done = 0;
  int          cyc = 0;
  int          done_seen[2] = '{0, 0};
  int          bytes_seen[2] = '{0, 0};
  int          last_start[2] = '{0, 0};
  logic        prev_busy[2] = '{1'b0, 1'b0};

  response_encoder_if #(.PAYLOAD_BYTES(4)) if0 ();
  response_encoder_if #(.PAYLOAD_BYTES(4)) if1 ();

  assign if0.cmd_send = cmd_send;
  assign if0.opcode   = opcode;
  assign if0.command  = command;
  assign if1.cmd_send = cmd_send;
  assign if1.opcode   = opcode;
  assign if1.command  = command;
  assign if0.tx_busy  = (tcnt0 != 0) || force_busy;
  assign if1.tx_busy  = (tcnt1 != 0) || force_busy;

  response_encoder #(.PAYLOAD_BYTES(4), .CHECKSUM_EN(0), .ACK_TIMEOUT(255)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave), .dbg_state_o(dbg0));
  response_encoder #(.PAYLOAD_BYTES(4), .CHECKSUM_EN(1), .ACK_TIMEOUT(16)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave), .dbg_state_o(dbg1));

  // clock / reset
  always #5 clock = ~clock;

  // transmitter models: busy for tx_len cycles starting the cycle after tx_start
  always @(posedge clock or negedge reset) begin
    if (!reset) tcnt0 <= 0;
    else if (if0.tx_start && !never_ack) tcnt0 <= tx_len;
    else if (tcnt0 > 0) tcnt0 <= tcnt0 - 1;
  end
  always @(posedge clock or negedge reset) begin
    if (!reset) tcnt1 <= 0;
    else if (if1.tx_start && !never_ack) tcnt1 <= tx_len;
    else if (tcnt1 > 0) tcnt1 <= tcnt1 - 1;
  end

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h (t=%0t)", name, k, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] qpop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // reference model: frame = opcode, payload MSB byte first, then XOR of all
  function automatic void push_frame(input logic [7:0] op, input logic [31:0] cmd);
    logic [7:0] b;
    logic [7:0] ck;
    ck = 8'h00;
    for (int i = 0; i < 5; i++) begin
      b  = (i == 0) ? op : 8'((cmd >> (8 * (4 - i))) & 32'hFF);
      ck = ck ^ b;
      exp_q0.push_back(b);
      exp_q1.push_back(b);
    end
    exp_q1.push_back(ck);
  endfunction

  // scoreboard monitor step for one DUT
  task automatic mon_step(input int k, input logic st, input logic [7:0] byt,
                          input logic bsy, input logic dn, input logic txb);
    if (st) begin
      bytes_seen[k]++;
      last_start[k] = cyc;
      if (qsize(k) == 0) begin
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_tx_start[dut%0d]: got byte %0h, expected no byte (t=%0t)",
                 k, byt, $time);
      end else begin
        check("tx_byte", k, 32'(byt), 32'(qpop(k)));
      end
      check("busy_at_start", k, 32'(bsy), 32'd1);
      check("spacing_before_start", k, 32'({prev_busy[k], txb}), 32'd0);
    end
    if (dn) begin
      done_seen[k]++;
      check("busy_at_done", k, 32'(bsy), 32'd0);
      check("bytes_left_at_done", k, 32'(qsize(k)), 32'd0);
      check("tx_busy_at_done", k, 32'(txb), 32'd0);
    end
    prev_busy[k] = txb;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      mon_step(0, if0.tx_start, if0.tx_byte, if0.busy, if0.done, if0.tx_busy);
      mon_step(1, if1.tx_start, if1.tx_byte, if1.busy, if1.done, if1.tx_busy);
    end else begin
      prev_busy[0] = 1'b0;
      prev_busy[1] = 1'b0;
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] op, input logic [31:0] cmd, input bit expect_it);
    @(negedge clock);
    opcode   = op;
    command  = cmd;
    cmd_send = 1'b1;
    if (expect_it) begin
      push_frame(op, cmd);
      exp_done++;
    end
    @(negedge clock);
    cmd_send = 1'b0;
    opcode   = 8'($urandom);
    command  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((done_seen[0] < exp_done || done_seen[1] < exp_done) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL done_wait: got done counts %0d/%0d, expected %0d", done_seen[0],
               done_seen[1], exp_done);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_byte"}, 0, 32'(if0.tx_byte), 32'd0);
    check({tag, "_tx_start"}, 0, 32'(if0.tx_start), 32'd0);
    check({tag, "_busy"}, 0, 32'(if0.busy), 32'd0);
    check({tag, "_done"}, 0, 32'(if0.done), 32'd0);
    check({tag, "_err"}, 0, 32'(if0.err), 32'd0);
    check({tag, "_tx_byte"}, 1, 32'(if1.tx_byte), 32'd0);
    check({tag, "_tx_start"}, 1, 32'(if1.tx_start), 32'd0);
    check({tag, "_busy"}, 1, 32'(if1.busy), 32'd0);
    check({tag, "_done"}, 1, 32'(if1.done), 32'd0);
    check({tag, "_err"}, 1, 32'(if1.err), 32'd0);
  endtask

  initial begin
    int n;
    int d0, d1;
    int b0;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // directed frame from the plan
    tx_len = 10;
    send(8'hA5, 32'h12345678, 1'b1);
    wait_done();
    check("err_after_frame", 0, 32'(if0.err), 32'd0);
    check("err_after_frame", 1, 32'(if1.err), 32'd0);

    // random frames, each with an ignored mid-frame request
    for (int i = 0; i < 8; i++) begin
      tx_len = $urandom_range(1, 12);
      send(8'($urandom), $urandom, 1'b1);
      repeat ($urandom_range(3, 15)) @(negedge clock);
      send(8'h01, $urandom, 1'b0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    send(8'h01, 32'h0, 1'b1);
    wait_done();

    // transmitter already busy at request
    force_busy = 1'b1;
    send(8'($urandom), $urandom, 1'b1);
    repeat (20) @(negedge clock);
    check("held_bytes_pending", 0, 32'(qsize(0)), 32'd5);
    check("held_bytes_pending", 1, 32'(qsize(1)), 32'd6);
    check("held_busy", 0, 32'(if0.busy), 32'd1);
    force_busy = 1'b0;
    wait_done();

    // timeout: transmitter never acknowledges
    never_ack = 1'b1;
    send(8'h3C, $urandom, 1'b0);
    exp_q0.push_back(8'h3C);
    exp_q1.push_back(8'h3C);
    d0 = -1;
    d1 = -1;
    n  = 0;
    while ((d0 < 0 || d1 < 0) && n < 600) begin
      @(negedge clock);
      n++;
      if (d0 < 0 && if0.err) d0 = cyc - last_start[0];
      if (d1 < 0 && if1.err) d1 = cyc - last_start[1];
    end
    check("err_set", 0, 32'(if0.err), 32'd1);
    check("err_set", 1, 32'(if1.err), 32'd1);
    check("err_delay_ok", 0, 32'(d0 >= 253 && d0 <= 258), 32'd1);
    check("err_delay_ok", 1, 32'(d1 >= 14 && d1 <= 19), 32'd1);
    check("busy_after_timeout", 0, 32'(if0.busy), 32'd0);
    check("busy_after_timeout", 1, 32'(if1.busy), 32'd0);
    check("no_done_on_timeout", 0, 32'(done_seen[0]), 32'(exp_done));
    check("no_done_on_timeout", 1, 32'(done_seen[1]), 32'(exp_done));
    repeat (5) @(negedge clock);
    check("err_sticky", 1, 32'(if1.err), 32'd1);
    never_ack = 1'b0;

    // next request clears err
    tx_len = 4;
    send(8'($urandom), $urandom, 1'b1);
    check("err_cleared", 0, 32'(if0.err), 32'd0);
    check("err_cleared", 1, 32'(if1.err), 32'd0);
    wait_done();

    // reset during the third byte
    tx_len = 8;
    b0 = bytes_seen[0];
    send(8'($urandom), $urandom, 1'b1);
    n = 0;
    while (bytes_seen[0] < b0 + 3 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("third_byte_reached", 0, 32'(bytes_seen[0] - b0), 32'd3);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    exp_q0.delete();
    exp_q1.delete();
    exp_done--;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    send(8'($urandom), $urandom, 1'b1);
    wait_done();

    check("final_done_count", 0, 32'(done_seen[0]), 32'(exp_done));
    check("final_done_count", 1, 32'(done_seen[1]), 32'(exp_done));
    check("final_queue_empty", 0, 32'(qsize(0)), 32'd0);
    check("final_queue_empty", 1, 32'(qsize(1)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
